gpio_port: RTL and testbench

Parametrised memory-mapped general-purpose I/O port for the memory stage of the pipelined CPU. It is the successor to the fixed 32-bit `gpio` bus and has the following capabilities:
- configurable pin count;
- per-pin direction control;
- metastability-safe input synchronisation;
- per-pin edge-detect interrupts with selectable polarity.

Register reads are registered, so read data aligns with the memory→writeback stage boundary.

---
 rtl/gpio_port_if.sv | 23 ++
 rtl/gpio_port.sv | 130 +++++++++++++
 tb/tb_gpio_port.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_port_if.sv
// gpio_port_if: register bus between the memory stage and the GPIO port.
//   addr  : byte address; addr[4:2] selects the register word
//   we    : write strobe, sampled on the rising clk edge
//   wdata : write data
//   rdata : registered read data for the address of the previous cycle
//   irq   : level interrupt request from the port
interface gpio_port_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr, we, wdata,
        input  rdata, irq
    );

    modport slave (
        input  addr, we, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/gpio_port.sv
// gpio_port: parametrised memory-mapped GPIO port with per-pin direction,
// synchronised inputs and per-pin edge-detect interrupts.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : register bus (slave side): addr/we/wdata in, rdata/irq out
//   gpio : WIDTH bidirectional pins, driven from OUT where DIR=1
// Register words: 0 DATA (wr OUT / rd SYNC), 1 DIR, 2 IE, 3 POL (1=rising),
// 4 IS (write-1-to-clear), 5..7 unmapped.
module gpio_port #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_port_if.slave       bus,
    inout  wire  [WIDTH-1:0] gpio
);

    typedef enum logic [2:0] {
        REG_DATA = 3'd0,
        REG_DIR  = 3'd1,
        REG_IE   = 3'd2,
        REG_POL  = 3'd3,
        REG_IS   = 3'd4
    } reg_sel_e;

    // Edges are ignored until the chain and PREV both hold sampled pin values.
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);

    logic [WIDTH-1:0]                  out_q, out_d;
    logic [WIDTH-1:0]                  dir_q, dir_d;
    logic [WIDTH-1:0]                  ie_q, ie_d;
    logic [WIDTH-1:0]                  pol_q, pol_d;
    logic [WIDTH-1:0]                  is_q, is_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [31:0]                       rdata_q, rdata_d;
    logic [PW-1:0]                     prime_q, prime_d;

    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wr_bits;
    logic             primed;
    reg_sel_e         sel;
    logic             unused_bus_bits;

    assign sel       = reg_sel_e'(bus.addr[4:2]);
    assign wr_bits   = bus.wdata[WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];
    assign primed    = (prime_q == PW'(PRIME_MAX));

    // Byte-lane bits and wdata bits above WIDTH carry no information here.
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

    // Rising edge where POL=1, falling edge where POL=0.
    assign edge_hit = (pol_q & sync_last & ~prev_q) | (~pol_q & ~sync_last & prev_q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statements can leave it unassigned and infer a latch.
        out_d   = out_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        pol_d   = pol_q;
        is_d    = is_q;
        rdata_d = '0;
        prime_d = primed ? prime_q : prime_q + PW'(1);
        sync_d  = {sync_q[SYNC_STAGES-2:0], gpio};

        case (sel)
            REG_DATA: rdata_d = 32'(sync_last);
            REG_DIR:  rdata_d = 32'(dir_q);
            REG_IE:   rdata_d = 32'(ie_q);
            REG_POL:  rdata_d = 32'(pol_q);
            REG_IS:   rdata_d = 32'(is_q);
            default:  rdata_d = '0;
        endcase

        if (bus.we) begin
            case (sel)
                REG_DATA: out_d = wr_bits;
                REG_DIR:  dir_d = wr_bits;
                REG_IE:   ie_d  = wr_bits;
                REG_POL:  pol_d = wr_bits;
                REG_IS:   is_d  = is_q & ~wr_bits;
                default:  ;
            endcase
        end

        // Applied after the clear so a same-cycle event beats a W1C.
        is_d = is_d | (edge_hit & {WIDTH{primed}});
    end

    // NOTE: every register, including the synchroniser chain, is reset so edge
    // detection and the priming window start from a known baseline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            pol_q   <= '1;
            is_q    <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            prime_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            out_q   <= out_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            pol_q   <= pol_d;
            is_q    <= is_d;
            sync_q  <= sync_d;
            prev_q  <= sync_last;
            rdata_q <= rdata_d;
            prime_q <= prime_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.irq   = |(is_q & ie_q);

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: self-checking bench for gpio_port. A 32-pin instance is
// compared every cycle against a queue-based model of pin history; an 8-pin
// instance covers the width rules. Undriven pins are pulled high so a
// tri-stated pin reads 1 and is distinguishable from a driven 0.
module tb_gpio_port;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] gpio;
    wire  [7:0]  g8;
    logic [31:0] ext_en;
    logic [31:0] ext_val;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_port_if bus ();
    gpio_port_if bus8 ();

    gpio_port #(.WIDTH(32), .SYNC_STAGES(SS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gpio (gpio)
    );

    gpio_port #(.WIDTH(8), .SYNC_STAGES(SS)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus8),
        .gpio (g8)
    );

    for (genvar i = 0; i < 32; i++) begin : g_ext
        pullup (gpio[i]);
        assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end
    for (genvar i = 0; i < 8; i++) begin : g_pu8
        pullup (g8[i]);
    end

    always #5 clk = ~clk;

    // ---------------- reference model (32-pin instance) ----------------
    logic [31:0] m_out, m_dir, m_ie, m_pol, m_is, m_rdata;
    logic [31:0] samples[$];   // pin value seen at each edge since reset release

    function automatic logic [31:0] model_pins();
        logic [31:0] p;
        for (int i = 0; i < 32; i++)
            p[i] = m_dir[i] ? m_out[i] : (ext_en[i] ? ext_val[i] : 1'b1);
        return p;
    endfunction

    // SYNC shows the pin as it was SS edges ago; PREV one edge older still.
    function automatic logic [31:0] m_sync();
        int n = samples.size();
        return (n >= SS) ? samples[n-SS] : 32'h0;
    endfunction

    function automatic logic [31:0] m_prev();
        int n = samples.size();
        return (n >= SS + 1) ? samples[n-SS-1] : 32'h0;
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_ie = '0; m_pol = '1; m_is = '0; m_rdata = '0;
        samples.delete();
    endtask

    task automatic model_edge(input logic [31:0] pin_pre);
        logic [31:0] s, p, ev, rd;
        if (!rst) begin
            model_reset();
            return;
        end
        s  = m_sync();
        p  = m_prev();
        ev = '0;
        case (bus.addr[4:2])
            3'd0:    rd = s;
            3'd1:    rd = m_dir;
            3'd2:    rd = m_ie;
            3'd3:    rd = m_pol;
            3'd4:    rd = m_is;
            default: rd = '0;
        endcase
        // Only once both SYNC and PREV reflect real pin samples.
        if (samples.size() >= SS + 1)
            for (int i = 0; i < 32; i++)
                if (m_pol[i] ? (s[i] && !p[i]) : (!s[i] && p[i])) ev[i] = 1'b1;
        if (bus.we)
            case (bus.addr[4:2])
                3'd0: m_out = bus.wdata;
                3'd1: m_dir = bus.wdata;
                3'd2: m_ie  = bus.wdata;
                3'd3: m_pol = bus.wdata;
                3'd4: m_is  = m_is & ~bus.wdata;
                default: ;
            endcase
        m_is    = m_is | ev;
        m_rdata = rd;
        samples.push_back(pin_pre);
    endtask

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs are stable from the previous falling edge; outputs
    // are compared on the following falling edge.
    task automatic tick();
        logic [31:0] pin_pre;
        pin_pre = model_pins();
        @(posedge clk);
        model_edge(pin_pre);
        @(negedge clk);
        check("rdata", bus.rdata, m_rdata);
        check("irq", 32'(bus.irq), 32'(|(m_is & m_ie)));
        check("pins", gpio, model_pins());
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.addr = a; bus.we = 1'b1; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input string tag, input logic [31:0] exp);
        bus.addr = a; bus.we = 1'b0;
        tick();
        check(tag, bus.rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.addr = '0;  bus.we = 1'b0;  bus.wdata = '0;
        bus8.addr = '0; bus8.we = 1'b0; bus8.wdata = '0;
        ext_en = 32'h1; ext_val = 32'h1;
        model_reset();

        // 1: reset state with pin 0 held high, then priming window.
        #3;
        check("rst_pins", gpio, 32'hFFFF_FFFF);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.addr = 5'((k % 8) * 4);
            tick();
        end
        bus_read(5'h04, "rst_dir", 32'h0);
        bus_read(5'h08, "rst_ie", 32'h0);
        bus_read(5'h0C, "rst_pol", 32'hFFFF_FFFF);
        bus_read(5'h10, "rst_is", 32'h0);
        bus_read(5'h1C, "rst_unmapped", 32'h0);
        check("prime_irq", 32'(bus.irq), 32'h0);

        // 2: drive the low byte; upper pins stay tri-stated.
        ext_en = '0;
        bus_write(5'h04, 32'h0000_00FF);
        check("dir_pins", gpio, 32'hFFFF_FF00);
        bus_write(5'h00, 32'h0000_00A5);
        check("out_pins", gpio, 32'hFFFF_FFA5);
        ext_en = 32'hFFFF_FF00; ext_val = '0;
        repeat (SS) tick();
        bus_read(5'h00, "data_rd", 32'h0000_00A5);

        // 3: rising edge on pin 3 via output loopback, then W1C.
        bus_write(5'h10, 32'hFFFF_FFFF);
        bus_write(5'h08, 32'h8);
        bus_write(5'h0C, 32'h8);
        bus_write(5'h00, 32'h0000_00AD);
        bus.addr = 5'h10;
        for (int k = 1; k <= SS + 1; k++) begin
            tick();
            check("irq_rise3", 32'(bus.irq), (k == SS + 1) ? 32'h1 : 32'h0);
        end
        bus_read(5'h10, "is_rise3", 32'h8);
        bus_write(5'h10, 32'h8);
        check("irq_w1c", 32'(bus.irq), 32'h0);
        bus_read(5'h10, "is_w1c", 32'h0);

        // 4: falling-edge polarity on pin 5; the rise must stay silent.
        bus_write(5'h08, 32'h28);
        bus_write(5'h00, 32'h0000_008D);
        repeat (SS + 3) tick();
        bus_write(5'h10, 32'h20);
        bus_write(5'h00, 32'h0000_00AD);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_rise5", 32'(bus.irq), 32'h0);
        end
        bus_write(5'h00, 32'h0000_008D);
        for (int k = 1; k <= SS + 1; k++) begin
            tick();
            check("irq_fall5", 32'(bus.irq), (k == SS + 1) ? 32'h1 : 32'h0);
        end
        bus_read(5'h10, "is_fall5", 32'h20);

        // 5: W1C of IS[3] on the same edge a new rise sets it.
        bus_write(5'h10, 32'h20);
        bus_write(5'h00, 32'h0000_0085);
        repeat (SS + 3) tick();
        bus_write(5'h00, 32'h0000_008D);
        repeat (SS + 3) tick();
        check("is3_set", 32'(bus.irq), 32'h1);
        bus_write(5'h00, 32'h0000_0085);
        repeat (SS + 3) tick();
        bus_write(5'h00, 32'h0000_008D);
        repeat (SS) tick();
        bus_write(5'h10, 32'h8);
        check("collide_irq", 32'(bus.irq), 32'h1);
        bus_read(5'h10, "collide_is", 32'h8);

        // Randomised traffic; DIR writes stay off the externally driven half.
        ext_en = 32'hFFFF_0000;
        for (int k = 0; k < 600; k++) begin
            logic [4:0]  a;
            logic [31:0] d;
            if ($urandom_range(3) == 0) ext_val = $urandom();
            a = 5'($urandom_range(31));
            d = $urandom();
            if (a[4:2] == 3'd1) d[31:16] = '0;
            bus.addr = a; bus.we = 1'($urandom_range(1)); bus.wdata = d;
            tick();
        end
        bus.we = 1'b0;

        // 6: width rules on the 8-pin build.
        bus8.addr = 5'h04; bus8.we = 1'b1; bus8.wdata = 32'hFFFF_FFFF;
        tick();
        bus8.we = 1'b0;
        tick();
        check("w8_dir", bus8.rdata, 32'h0000_00FF);
        bus8.addr = 5'h14;
        tick();
        check("w8_unmapped", bus8.rdata, 32'h0);
        bus8.addr = 5'h00; bus8.we = 1'b1; bus8.wdata = 32'h0;
        tick();
        bus8.we = 1'b0;
        check("w8_driven", 32'(g8), 32'h0);

        // Raise irq on the 32-pin build, then reset asynchronously mid-run.
        ext_en = '0;
        bus_write(5'h04, 32'h0000_00FF);
        bus_write(5'h0C, 32'h0);
        bus_write(5'h08, 32'h20);
        bus_write(5'h00, 32'h20);
        repeat (SS + 3) tick();
        bus_write(5'h10, 32'hFFFF_FFFF);
        bus_write(5'h00, 32'h0);
        repeat (SS + 2) tick();
        check("pre_rst_irq", 32'(bus.irq), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("arst_pins", gpio, 32'hFFFF_FFFF);
        check("arst_pins8", 32'(g8), 32'hFF);
        check("arst_irq", 32'(bus.irq), 32'h0);
        check("arst_irq8", 32'(bus8.irq), 32'h0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        bus_read(5'h10, "post_rst_is", 32'h0);
        bus_read(5'h04, "post_rst_dir", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
